// File: rtl/gray_fifo_ptr_ctrl.sv
// gray_fifo_ptr_ctrl
// Single-clock FIFO pointer controller. Holds the binary read/write pointers
// (ADDR_W+1 bits, MSB is the wrap bit), drives the RAM addresses, produces
// registered full/empty/count, sticky overflow/underflow flags, and exports
// Gray-coded copies of both pointers that are registered on the same edge as
// the binary pointers, so they never lag and change one bit at a time.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   wr_en       write request
//   rd_en       read request
//   clr_err     synchronous clear of the sticky error flags
//   wr_addr     RAM write address (low ADDR_W bits of the write pointer)
//   rd_addr     RAM read address (low ADDR_W bits of the read pointer)
//   wr_accept   combinational: wr_en & ~full
//   rd_accept   combinational: rd_en & ~empty
//   wr_ptr_gray registered Gray code of the write pointer
//   rd_ptr_gray registered Gray code of the read pointer
//   full        registered, FIFO holds 2**ADDR_W entries
//   empty       registered, FIFO holds 0 entries
//   count       registered occupancy 0..2**ADDR_W
//   overflow    sticky, write attempted while full
//   underflow   sticky, read attempted while empty
module gray_fifo_ptr_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR_W:0] wr_bin_q, wr_bin_d;
  logic [ADDR_W:0] rd_bin_q, rd_bin_d;
  logic [ADDR_W:0] wr_gray_q, wr_gray_d;
  logic [ADDR_W:0] rd_gray_q, rd_gray_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  always_comb begin
    wr_accept   = wr_en & ~full_q;
    rd_accept   = rd_en & ~empty_q;

    wr_bin_d    = wr_bin_q + {{ADDR_W{1'b0}}, wr_accept};
    rd_bin_d    = rd_bin_q + {{ADDR_W{1'b0}}, rd_accept};

    // Gray is derived from the next binary value so both register together.
    wr_gray_d   = bin2gray(wr_bin_d);
    rd_gray_d   = bin2gray(rd_bin_d);

    empty_d     = (wr_gray_d == rd_gray_d);
    // Full in Gray space: the top two bits differ, the rest match.
    full_d      = (wr_gray_d == {~rd_gray_d[ADDR_W:ADDR_W-1], rd_gray_d[ADDR_W-2:0]});
    count_d     = wr_bin_d - rd_bin_d;

    // A new error in the same cycle as clr_err must survive the clear.
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q    <= '0;
      rd_bin_q    <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      rd_bin_q    <= rd_bin_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_addr     = wr_bin_q[ADDR_W-1:0];
  assign rd_addr     = rd_bin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign rd_ptr_gray = rd_gray_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Testbench for gray_fifo_ptr_ctrl: directed scenarios plus a randomized
// stretch, checked every cycle against an occupancy/pointer-count model.
module tb_gray_fifo_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int PMOD   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_accept, rd_accept;
  logic [ADDR_W:0]   wr_ptr_gray, rd_ptr_gray;
  logic              full, empty;
  logic [ADDR_W:0]   count;
  logic              overflow, underflow;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  gray_fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_accept(wr_accept), .rd_accept(rd_accept),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: number of stored entries plus pointer counts mod 32.
  int m_wr = 0, m_rd = 0, m_occ = 0;
  bit m_ovf = 0, m_unf = 0;
  bit m_wacc, m_racc;
  assign m_wacc = wr_en && (m_occ < DEPTH);
  assign m_racc = rd_en && (m_occ > 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr <= 0; m_rd <= 0; m_occ <= 0; m_ovf <= 0; m_unf <= 0;
    end else begin
      m_wr  <= (m_wr + int'(m_wacc)) % PMOD;
      m_rd  <= (m_rd + int'(m_racc)) % PMOD;
      m_occ <= m_occ + int'(m_wacc) - int'(m_racc);
      if (wr_en && m_occ == DEPTH) m_ovf <= 1'b1;
      else if (clr_err)            m_ovf <= 1'b0;
      if (rd_en && m_occ == 0)     m_unf <= 1'b1;
      else if (clr_err)            m_unf <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Per-cycle compare, away from the active edge.
  logic [ADDR_W:0] prev_wg, prev_rg;
  int  prev_mw, prev_mr;
  bit  prev_valid = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_addr",     int'(wr_addr),     m_wr % DEPTH);
      chk("rd_addr",     int'(rd_addr),     m_rd % DEPTH);
      chk("wr_accept",   int'(wr_accept),   int'(m_wacc));
      chk("rd_accept",   int'(rd_accept),   int'(m_racc));
      chk("wr_ptr_gray", int'(wr_ptr_gray), to_gray(m_wr));
      chk("rd_ptr_gray", int'(rd_ptr_gray), to_gray(m_rd));
      chk("full",        int'(full),        int'(m_occ == DEPTH));
      chk("empty",       int'(empty),       int'(m_occ == 0));
      chk("count",       int'(count),       m_occ);
      chk("overflow",    int'(overflow),    int'(m_ovf));
      chk("underflow",   int'(underflow),   int'(m_unf));
      if (prev_valid && !rst) begin
        chk("wr_gray_step", $countones(wr_ptr_gray ^ prev_wg), int'(m_wr != prev_mw));
        chk("rd_gray_step", $countones(rd_ptr_gray ^ prev_rg), int'(m_rd != prev_mr));
      end
    end
    prev_wg    <= wr_ptr_gray;
    prev_rg    <= rd_ptr_gray;
    prev_mw    <= m_wr;
    prev_mr    <= m_rd;
    prev_valid <= cmp_en && !rst;
  end

  // Present inputs for one edge, then return 2 time units after that edge.
  task automatic drive(input bit w, input bit r, input bit c);
    wr_en = w; rd_en = r; clr_err = c;
    @(posedge clk);
    #2;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int pw, pr;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state.
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_wgray", int'(wr_ptr_gray), 0);
    chk("rst_rgray", int'(rd_ptr_gray), 0);

    // Read while empty.
    drive(0, 1, 0);
    chk("unf_set", int'(underflow), 1);
    chk("unf_rgray", int'(rd_ptr_gray), 0);
    drive(0, 0, 1);
    chk("unf_clr", int'(underflow), 0);

    // Five writes.
    repeat (5) drive(1, 0, 0);
    chk("w5_gray", int'(wr_ptr_gray), 5'b00111);
    chk("w5_count", int'(count), 5);
    chk("w5_addr", int'(wr_addr), 5);

    // Fill to 16.
    repeat (11) drive(1, 0, 0);
    chk("w16_full", int'(full), 1);
    chk("w16_gray", int'(wr_ptr_gray), 5'b11000);
    chk("w16_count", int'(count), 16);
    wr_en = 1'b1;
    #1;
    chk("w17_accept", int'(wr_accept), 0);
    drive(1, 0, 0);
    chk("w17_ovf", int'(overflow), 1);
    chk("w17_gray", int'(wr_ptr_gray), 5'b11000);

    // Simultaneous while full.
    drive(1, 1, 0);
    chk("wrf_full", int'(full), 0);
    chk("wrf_count", int'(count), 15);
    chk("wrf_rgray", int'(rd_ptr_gray), 5'b00001);
    chk("wrf_wgray", int'(wr_ptr_gray), 5'b11000);

    // Drain to 3, then stream across the pointer wrap.
    repeat (12) drive(0, 1, 0);
    chk("prime_count", int'(count), 3);
    repeat (40) drive(1, 1, 0);
    chk("stream_count", int'(count), 3);
    chk("stream_wgray", int'(wr_ptr_gray), to_gray(24));
    chk("stream_rgray", int'(rd_ptr_gray), to_gray(21));

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin pw = 80; pr = 30; end
      else                   begin pw = 30; pr = 80; end
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 5);
    end

    // Overflow colliding with clr_err.
    do_reset();
    repeat (16) drive(1, 0, 0);
    drive(1, 0, 1);
    chk("ovf_vs_clr", int'(overflow), 1);
    drive(0, 0, 1);
    chk("ovf_clr", int'(overflow), 0);
    drive(1, 0, 0);
    chk("ovf_reset_again", int'(overflow), 1);
    repeat (9) drive(0, 1, 0);
    chk("mid_count", int'(count), 7);

    // Asynchronous reset mid-stream with requests pending.
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_wgray", int'(wr_ptr_gray), 0);
    @(posedge clk);
    #2;
    chk("arst_hold_count", int'(count), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b0;
    repeat (3) drive(1, 0, 0);
    chk("post_rst_count", int'(count), 3);

    cmp_en = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_fifo_ptr_ctrl.md
Name: gray_fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer controller. It keeps the binary read and write pointers, generates full/empty/count, and flags error conditions. It also sequences binary-to-Gray conversion of both pointers each cycle. The Gray-coded pointers are exported registered and glitch-free, so a downstream synchroniser stage can carry them across a clock boundary. It sits between requesters and a dual-port RAM, and drives the RAM addresses.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W (16 by default).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
rd_en  input  1  read request
clr_err  input  1  synchronous clear of the sticky error flags
wr_addr  output  ADDR_W  RAM write address = wr_ptr_bin[ADDR_W-1:0]
rd_addr  output  ADDR_W  RAM read address = rd_ptr_bin[ADDR_W-1:0]
wr_accept  output  1  combinational: wr_en & ~full
rd_accept  output  1  combinational: rd_en & ~empty
wr_ptr_gray  output  ADDR_W+1  registered Gray code of the write pointer
rd_ptr_gray  output  ADDR_W+1  registered Gray code of the read pointer
full  output  1  registered; FIFO holds 2**ADDR_W entries
empty  output  1  registered; FIFO holds 0 entries
count  output  ADDR_W+1  registered occupancy, 0..2**ADDR_W
overflow  output  1  sticky; a write was attempted while full
underflow  output  1  sticky; a read was attempted while empty

Behaviour:
- Reset (async assert, takes effect immediately):
  - Binary and Gray pointers = 0.
  - count = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
- Internal pointers are ADDR_W+1 bits wide. The extra MSB is the wrap bit. Pointers increment modulo 2**(ADDR_W+1).
- Accept rules:
  - A write is accepted iff wr_en=1 and full=0. An accepted write increments wr_ptr_bin.
  - A read is accepted iff rd_en=1 and empty=0. An accepted read increments rd_ptr_bin.
  - A rejected request causes no pointer or flag change, apart from the sticky error flags.
- Gray conversion:
  - g[ADDR_W] = b[ADDR_W]; g[i] = b[i] ^ b[i+1] for i < ADDR_W.
  - It is applied to the NEXT binary pointer value and registered in the same edge as the binary pointer, so the Gray output and binary pointer never disagree (zero lag).
  - Successive wr_ptr_gray values differ in exactly one bit. The same holds for rd_ptr_gray.
- Flags (computed from next-state Gray pointers, then registered):
  - empty_next = (wr_gray_next == rd_gray_next).
  - full_next = (wr_gray_next == {~rd_gray_next[ADDR_W:ADDR_W-1], rd_gray_next[ADDR_W-2:0]}).
  - count_next = wr_bin_next - rd_bin_next, using ADDR_W+1-bit modular arithmetic.
- Latency: one cycle from an accepted request to the pointer, Gray, flag and count update.
- Simultaneous wr and rd:
  - Neither full nor empty: both accepted. count unchanged; both pointers advance.
  - While full: the read is accepted and the write is rejected. overflow is set. Next cycle full=0, count=2**ADDR_W-1.
  - While empty: the write is accepted and the read is rejected. underflow is set. Next cycle empty=0, count=1.
  - No same-cycle read-through of a write issued while empty.
- Sticky errors:
  - overflow is set on wr_en&full; underflow is set on rd_en&empty.
  - Both are cleared by clr_err.
  - If a set and clr_err occur in the same cycle, the set wins.
- Wrap-around: after 2**(ADDR_W+1) accepted operations a pointer returns to 0. Flags remain correct across the wrap.
- Reset mid-operation: all state returns to its reset values immediately. Requests pending in that cycle are discarded.
- Invariant for assertions: full and empty are never both 1. count==0 iff empty; count==2**ADDR_W iff full.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, wr_ptr_gray=rd_ptr_gray=5'b00000; rd_en pulse -> underflow=1, rd_ptr unchanged.
- 5 writes from reset -> wr_ptr_bin=5, wr_ptr_gray=5'b00111, count=5, wr_addr=4'd5; each step changes exactly one Gray bit.
- 16 writes -> full=1, wr_ptr_gray=5'b11000, count=16; 17th write -> wr_accept=0, overflow=1, pointers unchanged.
- While full, wr_en=rd_en=1 for 1 cycle -> next cycle full=0, count=15, rd_ptr_gray=5'b00001, wr_ptr_gray unchanged.
- Stream with wr_en=rd_en=1 for 40 cycles after priming 3 entries -> count stays 3, both pointers wrap past 31 to 0, and the flags are correct throughout.
- Assert rst mid-stream with count=7, and assert clr_err coincident with an overflow attempt -> immediate return to reset values; the error stays set when clr_err collides with a new overflow.
